// File: rtl/gp_count_adv_model.sv
// gp_count_adv_model: GreenPAK4 advanced counter model (COUNT8/COUNT14_ADV).
// Define GP_COUNT_ADV_POUT_EN to drive the parallel output POUT from the count.
module gp_count_adv_model #(
  parameter int WIDTH        = 8,
  parameter int COUNT_TO     = 1,
  parameter int RESET_TO_MAX = 0,
  parameter int CLKIN_DIVIDE = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             UP,
  input  logic             KEEP,
  output logic             OUT,
  output logic [WIDTH-1:0] POUT
);

  localparam int DW =
    (CLKIN_DIVIDE > 1) ? $clog2(CLKIN_DIVIDE) : 1;

  localparam logic [WIDTH-1:0] TOP = WIDTH'(COUNT_TO);

  localparam logic [WIDTH-1:0] RST_VAL =
    (RESET_TO_MAX != 0) ? TOP : '0;

  localparam logic [DW-1:0] DLAST = DW'(CLKIN_DIVIDE - 1);

  // Illegal configurations are rejected while the design is elaborated.
  generate
    if (WIDTH < 1 || WIDTH > 14) begin : g_bad_width
      $fatal(1, "ERROR: gp_count_adv_model illegal WIDTH %0d",
             WIDTH);
    end
    if (COUNT_TO < 0 || COUNT_TO >= (1 << WIDTH)) begin : g_bad_cnt
      $fatal(1, "ERROR: gp_count_adv_model illegal COUNT_TO %0d",
             COUNT_TO);
    end
    if (CLKIN_DIVIDE != 1 && CLKIN_DIVIDE != 4 &&
        CLKIN_DIVIDE != 12 && CLKIN_DIVIDE != 24 &&
        CLKIN_DIVIDE != 64) begin : g_bad_div
      $fatal(1, "ERROR: gp_count_adv_model illegal CLKIN_DIVIDE %0d",
             CLKIN_DIVIDE);
    end
`ifdef GP_COUNT_ADV_POUT_EN
    if (WIDTH > 8) begin : g_bad_pout
      $fatal(1, "ERROR: gp_count_adv_model POUT needs WIDTH<=8, got %0d",
             WIDTH);
    end
`endif
  endgenerate

  logic [DW-1:0]    div;
  logic             tick;
  logic [WIDTH-1:0] cnt;
  logic             out_q;

  assign tick = (div == DLAST);

  // Free-running prescaler; a tick is its last phase.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      div <= '0;
    end else if (tick) begin
      div <= '0;
    end else begin
      div <= div + DW'(1);
    end
  end

  // Counter and registered terminal pulse; OUT is one CLK wide.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt   <= RST_VAL;
      out_q <= 1'b0;
    end else if (!tick || KEEP) begin
      out_q <= 1'b0;
    end else if (UP) begin
      if (cnt >= TOP) begin
        cnt   <= '0;
        out_q <= 1'b1;
      end else begin
        cnt   <= cnt + WIDTH'(1);
        out_q <= 1'b0;
      end
    end else begin
      if (cnt == '0) begin
        cnt   <= TOP;
        out_q <= 1'b1;
      end else begin
        cnt   <= cnt - WIDTH'(1);
        out_q <= 1'b0;
      end
    end
  end

  assign OUT = out_q;

`ifdef GP_COUNT_ADV_POUT_EN
  assign POUT = cnt;
`else
  assign POUT = '0;
`endif

endmodule

// File: tb/tb_gp_count_adv_model.sv
// tb_gp_count_adv_model: directed checks of gp_count_adv_model
// across several parameter sets sharing one clock and control inputs.
module tb_gp_count_adv_model;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic up = 1'b0;
  logic keep = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic       out_a, out_b, out_c, out_d, out_f;
  logic [7:0] pout_a, pout_b, pout_c, pout_d, pout_f;

  gp_count_adv_model #(.WIDTH(8), .COUNT_TO(3)) u_a (
    .CLK(clk), .RST(rst), .UP(up), .KEEP(keep),
    .OUT(out_a), .POUT(pout_a)
  );

  gp_count_adv_model #(.WIDTH(8), .COUNT_TO(5),
                       .CLKIN_DIVIDE(4)) u_b (
    .CLK(clk), .RST(rst), .UP(up), .KEEP(keep),
    .OUT(out_b), .POUT(pout_b)
  );

  gp_count_adv_model #(.WIDTH(8), .COUNT_TO(5)) u_c (
    .CLK(clk), .RST(rst), .UP(up), .KEEP(keep),
    .OUT(out_c), .POUT(pout_c)
  );

  gp_count_adv_model #(.WIDTH(8), .COUNT_TO(9),
                       .RESET_TO_MAX(1)) u_d (
    .CLK(clk), .RST(rst), .UP(up), .KEEP(keep),
    .OUT(out_d), .POUT(pout_d)
  );

  gp_count_adv_model #(.WIDTH(8), .COUNT_TO(0)) u_f (
    .CLK(clk), .RST(rst), .UP(up), .KEEP(keep),
    .OUT(out_f), .POUT(pout_f)
  );

`ifndef GP_COUNT_ADV_POUT_EN
  logic        out_e;
  logic [13:0] pout_e;

  gp_count_adv_model #(.WIDTH(14), .COUNT_TO(16383)) u_e (
    .CLK(clk), .RST(rst), .UP(up), .KEEP(keep),
    .OUT(out_e), .POUT(pout_e)
  );
`endif

  function automatic logic [7:0] pexp(input int c);
`ifdef GP_COUNT_ADV_POUT_EN
    return 8'(c);
`else
    return 8'h00;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic u);
    rst  = 1'b1;
    up   = u;
    keep = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    checks++;
    if (u_a.cnt !== 8'd0 || out_a !== 1'b0 || pout_a !== pexp(0)) begin
      errors++;
      $display("FAIL reset_a cnt=%0d out=%b pout=%0d want 0 0 %0d",
               u_a.cnt, out_a, pout_a, pexp(0));
    end
    checks++;
    if (u_d.cnt !== 8'd9 || out_d !== 1'b0 || pout_d !== pexp(9)) begin
      errors++;
      $display("FAIL reset_max cnt=%0d out=%b pout=%0d want 9 0 %0d",
               u_d.cnt, out_d, pout_d, pexp(9));
    end
  endtask

  task automatic test_down();
    int ec[8] = '{3, 2, 1, 0, 3, 2, 1, 0};
    int eo[8] = '{1, 0, 0, 0, 1, 0, 0, 0};
    do_reset(1'b0);
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (u_a.cnt !== 8'(ec[i]) || out_a !== 1'(eo[i]) ||
          pout_a !== pexp(ec[i])) begin
        errors++;
        $display("FAIL down[%0d] cnt=%0d out=%b pout=%0d want %0d %0d",
                 i, u_a.cnt, out_a, pout_a, ec[i], eo[i]);
      end
    end
  endtask

  task automatic test_up_flip();
    int ec[9] = '{1, 2, 3, 0, 1, 2, 1, 0, 3};
    int eo[9] = '{0, 0, 0, 1, 0, 0, 0, 0, 1};
    do_reset(1'b1);
    for (int i = 0; i < 9; i++) begin
      if (i == 6) up = 1'b0;
      step();
      checks++;
      if (u_a.cnt !== 8'(ec[i]) || out_a !== 1'(eo[i]) ||
          pout_a !== pexp(ec[i])) begin
        errors++;
        $display("FAIL up_flip[%0d] cnt=%0d out=%b want %0d %0d",
                 i, u_a.cnt, out_a, ec[i], eo[i]);
      end
    end
  endtask

  task automatic test_prescale();
    int k;
    int ecnt;
    logic eout;
    int pulses = 0;
    do_reset(1'b0);
    for (int n = 1; n <= 60; n++) begin
      step();
      k    = n / 4;
      ecnt = (6 - (k % 6)) % 6;
      eout = (n % 24 == 4);
      if (out_b === 1'b1) pulses++;
      checks++;
      if (u_b.cnt !== 8'(ecnt) || out_b !== eout) begin
        errors++;
        $display("FAIL div4[%0d] cnt=%0d out=%b want %0d %b",
                 n, u_b.cnt, out_b, ecnt, eout);
      end
    end
    checks++;
    if (pulses != 3) begin
      errors++;
      $display("FAIL div4_pulses got %0d want 3", pulses);
    end
  endtask

  task automatic test_keep();
    int ec[3] = '{1, 0, 5};
    int eo[3] = '{0, 0, 1};
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (u_c.cnt !== 8'd2) begin
      errors++;
      $display("FAIL keep_pre cnt=%0d want 2", u_c.cnt);
    end
    keep = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (u_c.cnt !== 8'd2 || out_c !== 1'b0 ||
          pout_c !== pexp(2)) begin
        errors++;
        $display("FAIL keep[%0d] cnt=%0d out=%b want 2 0",
                 i, u_c.cnt, out_c);
      end
    end
    keep = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (u_c.cnt !== 8'(ec[i]) || out_c !== 1'(eo[i])) begin
        errors++;
        $display("FAIL keep_resume[%0d] cnt=%0d out=%b want %0d %0d",
                 i, u_c.cnt, out_c, ec[i], eo[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (u_d.cnt !== 8'd4) begin
      errors++;
      $display("FAIL async_pre cnt=%0d want 4", u_d.cnt);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (u_d.cnt !== 8'd9 || out_d !== 1'b0 || pout_d !== pexp(9)) begin
      errors++;
      $display("FAIL async_rst cnt=%0d out=%b want 9 0",
               u_d.cnt, out_d);
    end
    do_reset(1'b0);
    step();
    checks++;
    if (out_a !== 1'b1 || u_a.cnt !== 8'd3) begin
      errors++;
      $display("FAIL drop_pre out=%b cnt=%0d want 1 3",
               out_a, u_a.cnt);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_a !== 1'b0 || u_a.cnt !== 8'd0) begin
      errors++;
      $display("FAIL drop_pulse out=%b cnt=%0d want 0 0",
               out_a, u_a.cnt);
    end
  endtask

  task automatic test_zero();
    logic eo[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) keep = 1'b1;
      if (i == 3) begin
        keep = 1'b0;
        up   = 1'b1;
      end
      step();
      checks++;
      if (u_f.cnt !== 8'd0 || out_f !== eo[i]) begin
        errors++;
        $display("FAIL zero[%0d] cnt=%0d out=%b want 0 %b",
                 i, u_f.cnt, out_f, eo[i]);
      end
    end
  endtask

`ifndef GP_COUNT_ADV_POUT_EN
  task automatic test_wide();
    int bad = 0;
    do_reset(1'b1);
    for (int i = 0; i < 16383; i++) begin
      step();
      if (out_e !== 1'b0 || pout_e !== 14'd0) bad++;
    end
    checks++;
    if (bad != 0 || u_e.cnt !== 14'd16383) begin
      errors++;
      $display("FAIL wide_run bad=%0d cnt=%0d want 0 16383",
               bad, u_e.cnt);
    end
    step();
    checks++;
    if (out_e !== 1'b1 || u_e.cnt !== 14'd0 || pout_e !== 14'd0) begin
      errors++;
      $display("FAIL wide_wrap out=%b cnt=%0d pout=%0d want 1 0 0",
               out_e, u_e.cnt, pout_e);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_down();
    test_up_flip();
    test_prescale();
    test_keep();
    test_async_reset();
    test_zero();
`ifndef GP_COUNT_ADV_POUT_EN
    test_wide();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
